// File: rtl/syscall_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syscall_unit: writeback-stage syscall service (print_int/print_char/exit)  |
// | streaming ASCII bytes on a valid/ready port, stalling the pipeline.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module syscall_unit #(
  parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
  parameter logic [31:0] CODE_EXIT       = 32'd10,
  parameter logic [31:0] CODE_PRINT_CHAR = 32'd11,
  parameter int          MAX_DIGITS      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_valid,
  input  logic [31:0] sys_v,
  input  logic [31:0] sys_a,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        stall,
  output logic        halted,
  output logic        bad_sys
);

  localparam int c_DEPTH_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DIV       = 3'd1,
    S_EMIT_SIGN = 3'd2,
    S_EMIT_DIG  = 3'd3,
    S_EMIT_CHAR = 3'd4,
    S_DONE      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [31:0]            r_mag;
  logic                   r_neg;
  logic [7:0]             r_char;
  logic [3:0]             r_rem;
  logic [4:0]             r_bitCnt;
  logic [7:0]             r_lifo [MAX_DIGITS];
  logic [c_DEPTH_W-1:0]   r_depth;
  logic                   r_badSys;

  logic [4:0]             w_trial;
  logic [4:0]             w_sub;
  logic                   w_qBit;
  logic [3:0]             w_newRem;
  logic [31:0]            w_quot;
  logic                   w_lastBit;
  logic                   w_known;
  logic [c_DEPTH_W-1:0]   w_topIdx;

  // Restoring divide by 10: the dividend shifts out of r_mag's MSB while the
  // quotient bits shift into its LSB, so after 32 steps r_mag holds the quotient.
  assign w_trial   = {r_rem, r_mag[31]};
  assign w_sub     = w_trial - 5'd10;
  assign w_qBit    = (w_trial >= 5'd10);
  assign w_newRem  = w_qBit ? w_sub[3:0] : w_trial[3:0];
  assign w_quot    = {r_mag[30:0], w_qBit};
  assign w_lastBit = (r_bitCnt == 5'd31);
  assign w_topIdx  = r_depth - {{(c_DEPTH_W-1){1'b0}}, 1'b1};
  assign w_known   = (sys_v == CODE_PRINT_INT) || (sys_v == CODE_PRINT_CHAR) ||
                     (sys_v == CODE_EXIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    stall       = 1'b0;
    halted      = 1'b0;
    bad_sys     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sys_valid) begin
          stall = 1'b1;
          if (sys_v == CODE_PRINT_CHAR)     w_nextState = S_EMIT_CHAR;
          else if (sys_v == CODE_PRINT_INT) w_nextState = S_DIV;
          else if (sys_v == CODE_EXIT)      w_nextState = S_HALT;
          else                              w_nextState = S_DONE;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (w_lastBit && (w_quot == 32'd0)) begin
          w_nextState = r_neg ? S_EMIT_SIGN : S_EMIT_DIG;
        end
      end
      S_EMIT_SIGN: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_data  = 8'h2D;
        if (out_ready) w_nextState = S_EMIT_DIG;
      end
      S_EMIT_DIG: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_data  = r_lifo[w_topIdx];
        if (out_ready && (r_depth == {{(c_DEPTH_W-1){1'b0}}, 1'b1})) begin
          w_nextState = S_DONE;
        end
      end
      S_EMIT_CHAR: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_data  = r_char;
        if (out_ready) w_nextState = S_DONE;
      end
      S_DONE: begin
        bad_sys     = r_badSys;
        w_nextState = S_IDLE;
      end
      S_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag    <= 32'd0;
      r_neg    <= 1'b0;
      r_char   <= 8'h00;
      r_rem    <= 4'd0;
      r_bitCnt <= 5'd0;
      r_depth  <= '0;
      r_badSys <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sys_valid) begin
            // Two's-complement magnitude; 0x80000000 maps onto itself as unsigned.
            r_mag    <= sys_a[31] ? (~sys_a + 32'd1) : sys_a;
            r_neg    <= sys_a[31];
            r_char   <= sys_a[7:0];
            r_rem    <= 4'd0;
            r_bitCnt <= 5'd0;
            r_depth  <= '0;
            r_badSys <= !w_known;
          end
        end
        S_DIV: begin
          r_bitCnt <= r_bitCnt + 5'd1;
          r_mag    <= w_quot;
          if (w_lastBit) begin
            r_rem   <= 4'd0;
            r_depth <= r_depth + {{(c_DEPTH_W-1){1'b0}}, 1'b1};
          end else begin
            r_rem   <= w_newRem;
          end
        end
        S_EMIT_DIG: begin
          if (out_ready) r_depth <= w_topIdx;
        end
        default: ;
      endcase
    end
  end

  // Digit storage needs no reset: r_depth alone defines what is valid.
  always_ff @(posedge clk) begin
    if ((r_state == S_DIV) && w_lastBit) begin
      r_lifo[r_depth] <= 8'h30 + {4'h0, w_newRem};
    end
  end

endmodule
`default_nettype wire
